// File: rtl/dvi_timing_pkg.sv
// rtl/dvi_timing_pkg.sv - raster defaults, totals helper and reader state type
package dvi_timing_pkg;

   localparam int CNT_W = 11;

   localparam int DEF_H_ACTIVE    = 640;
   localparam int DEF_H_FP        = 16;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_H_BP        = 48;
   localparam int DEF_V_ACTIVE    = 480;
   localparam int DEF_V_FP        = 10;
   localparam int DEF_V_SYNC      = 2;
   localparam int DEF_V_BP        = 33;
   localparam int DEF_PRIME_LEVEL = 256;

   typedef enum logic [1:0] {
      WAIT_FILL  = 2'd0,
      WAIT_FRAME = 2'd1,
      RUN        = 2'd2
   } reader_state_t;

   function automatic int span_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/dvi_timing_gen.sv
// rtl/dvi_timing_gen.sv - free-running h/v raster counters with stage-0 flags
module dvi_timing_gen
   import dvi_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic             dvi_clk,
   input  logic             reset_n,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             act0,
   output logic             hs0,
   output logic             vs0,
   output logic             frame_end
);

   localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_L = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_L = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic h_wrap;
   logic v_wrap;

   assign h_wrap = (h_cnt == H_LAST);
   assign v_wrap = (v_cnt == V_LAST);

   always_ff @(posedge dvi_clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_wrap) begin
         h_cnt <= '0;
         v_cnt <= v_wrap ? '0 : v_cnt + ONE;
      end else begin
         h_cnt <= h_cnt + ONE;
      end
   end

   assign act0      = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
   assign hs0       = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   assign vs0       = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
   assign frame_end = h_wrap && v_wrap;

endmodule

// File: rtl/dvi_frame_reader.sv
// rtl/dvi_frame_reader.sv - primes on FIFO fill, requests one word per active pixel
// and unpacks returned words into RGB aligned with hs/vs/de two cycles later.
module dvi_frame_reader
   import dvi_timing_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int PRIME_LEVEL = DEF_PRIME_LEVEL
) (
   input  logic        dvi_clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [8:0]  fifo_rdusedw,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   input  logic        underflow_clr,
   output logic        read_init,
   output logic [7:0]  dvi_r,
   output logic [7:0]  dvi_g,
   output logic [7:0]  dvi_b,
   output logic        dvi_hs,
   output logic        dvi_vs,
   output logic        dvi_de,
   output logic        frame_start,
   output logic        underflow,
   output logic [15:0] underflow_cnt,
   output logic        streaming
);

   localparam logic [8:0]  PRIME_THR = 9'(PRIME_LEVEL);
   localparam logic [15:0] CNT_MAX   = 16'hFFFF;

   reader_state_t    state;
   reader_state_t    state_next;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             act0;
   logic             hs0;
   logic             vs0;
   logic             frame_end;
   logic             first0;
   logic             run0;
   logic             act1;
   logic             hs1;
   logic             vs1;
   logic             run1;
   logic             first1;
   logic             pix_load;
   logic             ufl_evt;
   logic             unused_hi;

   dvi_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .dvi_clk   (dvi_clk),
      .reset_n   (reset_n),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .act0      (act0),
      .hs0       (hs0),
      .vs0       (vs0),
      .frame_end (frame_end)
   );

   always_ff @(posedge dvi_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= WAIT_FILL;
      end else begin
         state <= state_next;
      end
   end

   // Streaming only ever begins or ends on the last cycle of a frame.
   always_comb begin
      state_next = state;
      unique case (state)
         WAIT_FILL: begin
            if (enable && (fifo_rdusedw >= PRIME_THR)) begin
               state_next = WAIT_FRAME;
            end
         end
         WAIT_FRAME: begin
            if (!enable) begin
               state_next = WAIT_FILL;
            end else if (frame_end) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (frame_end && !enable) begin
               state_next = WAIT_FILL;
            end
         end
         default: state_next = WAIT_FILL;
      endcase
   end

   always_comb begin
      run0      = 1'b0;
      read_init = 1'b0;
      unique case (state)
         RUN: begin
            run0      = 1'b1;
            read_init = act0;
         end
         default: begin
            run0      = 1'b0;
            read_init = 1'b0;
         end
      endcase
   end

   assign first0 = (h_cnt == '0) && (v_cnt == '0);

   always_ff @(posedge dvi_clk or negedge reset_n) begin
      if (!reset_n) begin
         act1   <= 1'b0;
         hs1    <= 1'b0;
         vs1    <= 1'b0;
         run1   <= 1'b0;
         first1 <= 1'b0;
      end else begin
         act1   <= act0;
         hs1    <= hs0;
         vs1    <= vs0;
         run1   <= run0;
         first1 <= first0;
      end
   end

   // in_valid belongs to the request issued in the previous cycle.
   assign pix_load  = act1 && run1 && in_valid;
   assign ufl_evt   = act1 && run1 && !in_valid;
   assign unused_hi = ^in_data[31:24];

   always_ff @(posedge dvi_clk or negedge reset_n) begin
      if (!reset_n) begin
         dvi_r       <= 8'h00;
         dvi_g       <= 8'h00;
         dvi_b       <= 8'h00;
         dvi_hs      <= ~HS_POL;
         dvi_vs      <= ~VS_POL;
         dvi_de      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         dvi_r       <= pix_load ? in_data[23:16] : 8'h00;
         dvi_g       <= pix_load ? in_data[15:8]  : 8'h00;
         dvi_b       <= pix_load ? in_data[7:0]   : 8'h00;
         dvi_hs      <= hs1 ? HS_POL : ~HS_POL;
         dvi_vs      <= vs1 ? VS_POL : ~VS_POL;
         dvi_de      <= act1;
         frame_start <= run1 && first1 && act1;
      end
   end

   always_ff @(posedge dvi_clk or negedge reset_n) begin
      if (!reset_n) begin
         underflow     <= 1'b0;
         underflow_cnt <= 16'h0000;
      end else if (underflow_clr) begin
         underflow     <= 1'b0;
         underflow_cnt <= 16'h0000;
      end else if (ufl_evt) begin
         underflow <= 1'b1;
         if (underflow_cnt != CNT_MAX) begin
            underflow_cnt <= underflow_cnt + 16'h0001;
         end
      end
   end

   // Registered from the next state so it tracks the state register exactly.
   always_ff @(posedge dvi_clk or negedge reset_n) begin
      if (!reset_n) begin
         streaming <= 1'b0;
      end else begin
         streaming <= (state_next == RUN);
      end
   end

endmodule

// File: tb/tb_dvi_frame_reader.sv
// tb/tb_dvi_frame_reader.sv - scoreboard bench for dvi_frame_reader on a shrunken raster
`timescale 1ns/1ps
module tb_dvi_frame_reader;

   localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3;
   localparam int VA = 6, VFP = 1, VSW = 2, VBP = 1;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FRAME = HT * VT;
   localparam bit HS_POL = 1'b0;
   localparam bit VS_POL = 1'b1;
   localparam int PRIME = 256;

   logic        dvi_clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [8:0]  fifo_rdusedw;
   logic [31:0] in_data;
   logic        in_valid;
   logic        underflow_clr;
   logic        read_init;
   logic [7:0]  dvi_r, dvi_g, dvi_b;
   logic        dvi_hs, dvi_vs, dvi_de;
   logic        frame_start;
   logic        underflow;
   logic [15:0] underflow_cnt;
   logic        streaming;

   typedef struct packed {
      logic [23:0] rgb;
      logic        fs;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   dvi_frame_reader #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
      .HS_POL (HS_POL), .VS_POL (VS_POL), .PRIME_LEVEL (PRIME)
   ) dut (
      .dvi_clk       (dvi_clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .fifo_rdusedw  (fifo_rdusedw),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .underflow_clr (underflow_clr),
      .read_init     (read_init),
      .dvi_r         (dvi_r),
      .dvi_g         (dvi_g),
      .dvi_b         (dvi_b),
      .dvi_hs        (dvi_hs),
      .dvi_vs        (dvi_vs),
      .dvi_de        (dvi_de),
      .frame_start   (frame_start),
      .underflow     (underflow),
      .underflow_cnt (underflow_cnt),
      .streaming     (streaming)
   );

   always #5 dvi_clk = ~dvi_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         if (bad <= 30) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit is_act(input int p);
      return ((p % HT) < HA) && ((p / HT) < VA);
   endfunction

   function automatic bit is_hs(input int p);
      int h;
      h = p % HT;
      return (h >= HA + HFP) && (h < HA + HFP + HSW);
   endfunction

   function automatic bit is_vs(input int p);
      int v;
      v = p / HT;
      return (v >= VA + VFP) && (v < VA + VFP + VSW);
   endfunction

   function automatic bit sched_en(input int seg, input int f, input int v);
      if (seg != 0) return 1'b1;
      return !((f == 6 && v >= 2) || (f == 7 && (v < 3 || v >= 5)) || (f == 8 && v < 1));
   endfunction

   function automatic bit sched_drop(input int seg, input int f, input int v, input int h);
      if (seg != 0) return 1'b0;
      if (f == 4 && v == 2 && h >= 1 && h <= 3) return 1'b1;
      if (f == 4 && v == 4 && h == 5) return 1'b1;
      if (f == 5) return ($urandom_range(0, 7) == 0);
      return 1'b0;
   endfunction

   function automatic bit sched_clr(input int seg, input int f, input int v, input int h);
      if (seg != 0) return 1'b0;
      if (f == 4 && v == 3 && h == 0) return 1'b1;
      if (f == 4 && v == 4 && h == 6) return 1'b1;
      if (f == 5 || f == 6) return ($urandom_range(0, 39) == 0);
      return 1'b0;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_read_init"}, read_init, 0);
      check({tag, "_rgb"}, {dvi_r, dvi_g, dvi_b}, 0);
      check({tag, "_hs"}, dvi_hs, !HS_POL);
      check({tag, "_vs"}, dvi_vs, !VS_POL);
      check({tag, "_de"}, dvi_de, 0);
      check({tag, "_frame_start"}, frame_start, 0);
      check({tag, "_underflow"}, underflow, 0);
      check({tag, "_underflow_cnt"}, underflow_cnt, 0);
      check({tag, "_streaming"}, streaming, 0);
   endtask

   // Monitor: every displayed pixel consumes one expected entry.
   initial begin
      exp_t m;
      forever begin
         @(negedge dvi_clk);
         if (reset_n === 1'b1) begin
            if (dvi_de === 1'b1) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_de actual=1 required=0 at %0t", $time);
               end else begin
                  m = sb.pop_front();
                  check("pixel_rgb", {dvi_r, dvi_g, dvi_b}, m.rgb);
                  check("pixel_frame_start", frame_start, m.fs);
               end
            end else begin
               check("idle_frame_start", frame_start, 0);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, seg, p, h, v, f, q, req_cnt;
      bit m_stream, m_armed, m_uflag, done, streamed_frame;
      bit pend_req, pend_drop, prev_act, exp_req, drop, ev;
      logic [15:0] m_ucnt;
      logic [31:0] pend_word, word;
      exp_t e;

      reset_n = 1'b0;
      enable = 1'b0;
      fifo_rdusedw = '0;
      in_data = '0;
      in_valid = 1'b0;
      underflow_clr = 1'b0;
      repeat (5) @(posedge dvi_clk);
      #1;
      check_idle_outputs("reset");
      reset_n = 1'b1;

      c = 0; seg = 0; done = 0; req_cnt = 0; streamed_frame = 0;
      m_stream = 0; m_armed = 0; m_uflag = 0; m_ucnt = '0;
      pend_req = 0; pend_drop = 0; prev_act = 0; pend_word = '0;

      while (!done) begin
         p = c % FRAME; h = p % HT; v = p / HT; f = c / FRAME;

         check("streaming", streaming, m_stream);
         check("underflow", underflow, m_uflag);
         check("underflow_cnt", underflow_cnt, m_ucnt);
         if (c >= 2) begin
            q = (c - 2) % FRAME;
            check("de", dvi_de, is_act(q));
            check("hs", dvi_hs, is_hs(q) ? HS_POL : !HS_POL);
            check("vs", dvi_vs, is_vs(q) ? VS_POL : !VS_POL);
         end else begin
            check("de_fill", dvi_de, 0);
            check("hs_fill", dvi_hs, !HS_POL);
            check("vs_fill", dvi_vs, !VS_POL);
         end

         if (pend_req) begin
            in_valid = !pend_drop;
            in_data = pend_word;
         end else begin
            in_valid = prev_act ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data = $urandom();
         end
         enable = sched_en(seg, f, v);
         fifo_rdusedw = (seg == 0 && (f < 2 || (f == 2 && p < 50)))
                        ? 9'($urandom_range(0, PRIME - 1)) : 9'($urandom_range(PRIME, 511));
         underflow_clr = sched_clr(seg, f, v, h);

         exp_req = m_stream && is_act(p);
         check("read_init", read_init, exp_req);
         if (p == 0) begin
            req_cnt = 0;
            streamed_frame = m_stream;
         end
         if (read_init === 1'b1) req_cnt++;

         drop = exp_req && sched_drop(seg, f, v, h);
         word = $urandom();
         if (is_act(p)) begin
            e.rgb = (exp_req && !drop) ? word[23:0] : 24'h0;
            e.fs = exp_req && (p == 0);
            sb.push_back(e);
         end

         ev = pend_req && pend_drop;
         if (underflow_clr) begin
            m_uflag = 0;
            m_ucnt = '0;
         end else if (ev) begin
            m_uflag = 1;
            if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
         end

         if (p == FRAME - 1) check("req_per_frame", req_cnt, streamed_frame ? HA * VA : 0);

         if (m_stream) begin
            if (p == FRAME - 1 && !enable) m_stream = 0;
         end else if (m_armed) begin
            if (!enable) m_armed = 0;
            else if (p == FRAME - 1) begin
               m_stream = 1;
               m_armed = 0;
            end
         end else if (enable && fifo_rdusedw >= PRIME) begin
            m_armed = 1;
         end

         pend_req = exp_req; pend_drop = drop; pend_word = word; prev_act = is_act(p);

         if (seg == 0 && f == 9 && v == 3 && h == 2) begin
            #2 reset_n = 1'b0;
            #1 check_idle_outputs("async_reset");
            repeat (3) @(posedge dvi_clk);
            #1 reset_n = 1'b1;
            sb.delete();
            m_stream = 0; m_armed = 0; m_uflag = 0; m_ucnt = '0;
            pend_req = 0; pend_drop = 0; prev_act = 0;
            req_cnt = 0; streamed_frame = 0;
            c = 0; seg = 1;
         end else if (seg == 1 && c == 3 * FRAME - 1) begin
            done = 1;
         end else begin
            @(posedge dvi_clk);
            #1;
            c++;
         end
      end

      repeat (3) @(posedge dvi_clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dvi_frame_reader.md
Name: dvi_frame_reader

Overview:
- Display-side consumer of the DDR2 frame bus read FIFO, clocked on dvi_clk.
- Generates VGA/DVI raster timing and issues the read request (`read_init`) one cycle ahead of each active pixel.
- Unpacks returned 32-bit words into 8-bit RGB, aligned with `hs`/`vs`/`de`.
- Primes on FIFO fill level, starts cleanly at a frame boundary, and counts underflows.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, active level of `dvi_hs`
- VS_POL, 0, active level of `dvi_vs`
- PRIME_LEVEL, 256, minimum `fifo_rdusedw` before streaming starts (must be < 512)

Ports:
- dvi_clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  request to stream frames
- fifo_rdusedw  in  9  read FIFO read-side fill level
- in_data  in  32  FIFO word; R=[23:16], G=[15:8], B=[7:0]
- in_valid  in  1  `in_data` valid; arrives exactly 1 cycle after `read_init`
- underflow_clr  in  1  clears sticky underflow flag and counter
- read_init  out  1  read request to FIFO
- dvi_r  out  8  red
- dvi_g  out  8  green
- dvi_b  out  8  blue
- dvi_hs  out  1  horizontal sync
- dvi_vs  out  1  vertical sync
- dvi_de  out  1  data enable
- frame_start  out  1  one-cycle pulse coincident with the first active pixel output of a streamed frame
- underflow  out  1  sticky: an active pixel in RUN found `in_valid` low
- underflow_cnt  out  16  saturating underflow count
- streaming  out  1  high in RUN

Behaviour:
- Reset (async assert, sync release):
  - h_cnt=0, v_cnt=0, state=WAIT_FILL.
  - All outputs 0, except `dvi_hs` = ~HS_POL and `dvi_vs` = ~VS_POL (inactive).
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of H params (800).
  - v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 (525), then wraps to 0.
  - Both are 11 bits and run in every state after reset.
- Stage-0 raster flags:
  - act0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs0 asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs0 likewise on v_cnt.
- Request: `read_init` = act0 && state==RUN (combinational). No request is ever made outside active region or outside RUN.
- Pipeline:
  - act/hs/vs are delayed 2 registers to `dvi_de`/`dvi_hs`/`dvi_vs`, with polarity applied at the output register.
  - Stage 1 (cycle after request): if act1 && run1 && in_valid, the RGB register loads the unpacked `in_data`; otherwise it loads 0.
  - Total latency from counter position to pins: 2 dvi_clk.
- State machine:
  - WAIT_FILL: `read_init`=0. Go to WAIT_FRAME when `fifo_rdusedw` >= PRIME_LEVEL && enable.
  - WAIT_FRAME: go to RUN on the cycle where h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1, so the first request is at (0,0). If enable drops, return to WAIT_FILL.
  - RUN: continue. On the last cycle of a frame, go to WAIT_FILL if enable==0. Enable dropping mid-frame takes effect only at frame end; no partial frames are streamed.
- Underflow:
  - When run1 && act1 && !in_valid: pixel output is 0, `underflow` sets, and the counter increments (saturating at 0xFFFF).
  - No resync; timing and streaming continue.
  - If `underflow_clr` coincides with an underflow event, the clear wins for the flag and the counter becomes 0.
- `frame_start`: pulses when the output-stage pixel is (0,0) of a frame requested in RUN.
- `streaming` = (state==RUN), registered.
- Reset mid-frame: immediately returns to WAIT_FILL with counters at 0. FIFO contents are not flushed by this block.

Decomposition:
- Package `dvi_timing_pkg`:
  - 640x480@60 default constants and H_TOTAL/V_TOTAL derivation function.
  - State enum {WAIT_FILL, WAIT_FRAME, RUN}.
- Sub-module `dvi_timing_gen`: h/v counters plus act0/hs0/vs0 and end-of-frame strobe.
- Parent owns the FSM, request logic, 2-stage pipeline and underflow logic.

Test Plan:
- Reset: hold `reset_n`=0 for 5 cycles → all outputs 0, `dvi_hs`/`dvi_vs`=1 with POL=0; release → first `dvi_hs` low at h_cnt=656+2, width 96 cycles.
- Priming: `enable`=1, `fifo_rdusedw`=255 → no `read_init` for 2 frames; raise to 256 mid-frame → first `read_init` at (0,0) of the next frame; `frame_start` 2 cycles later.
- Streaming: model FIFO returns word = pixel index, `in_valid` 1 cycle after `read_init` → `dvi_r:g:b` = index[23:0] aligned with `dvi_de`; exactly 307200 requests per frame, `underflow`=0.
- Underflow: force `in_valid`=0 for 3 requested pixels on line 10 → those pixels are 0, `underflow`=1, `underflow_cnt`=3; `underflow_clr` pulse → 0.
- Disable: drop `enable` at line 100 → requests continue to line 479, none in the next frame, `streaming`=0 after the frame end.
- Async reset while in RUN at line 200 → `read_init` drops without a clock edge; state WAIT_FILL after release.
